fetch_unit: RTL and testbench

Instruction-fetch stage of the vector processor pipeline, directly upstream of the Decode stage. It generates word addresses into instruction memory with a single-outstanding request/response handshake and buffers returned words in a small prefetch FIFO. It drives the registered IF/ID outputs `instruction` and `PC` that Decode consumes. It also handles stall from the hazard logic and redirect on taken branches, including discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned INSTR_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FLUSH_WAIT
    } fetch_state_t;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, synchronous clear, first-word-fall-through read.
module fetch_fifo #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data_c,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty_c,
    output logic              o_full_c
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_count   = r_count;
    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_data_c  = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c;

    // Storage array carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests, prefetch FIFO, registered IF/ID outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH            = ADDR_W,
    parameter int unsigned INSTRUCTIONWIDTH = INSTR_W,
    parameter int unsigned DEPTH            = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        imem_req,
    output logic [WIDTH-1:0]            imem_addr,
    input  logic                        imem_valid,
    input  logic [INSTRUCTIONWIDTH-1:0] imem_data,
    input  logic                        stall,
    input  logic                        branchTaken,
    input  logic [WIDTH-1:0]            branchTarget,
    output logic [INSTRUCTIONWIDTH-1:0] instruction,
    output logic [WIDTH-1:0]            PC,
    output logic                        instrValid
);

    localparam int unsigned ENTRY_W = INSTRUCTIONWIDTH + WIDTH;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    fetch_state_t       r_state;
    logic [WIDTH-1:0]   r_fetch_pc;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_empty;
    logic               w_full;

    // A response is only accepted for a live (non-flushed) request.
    assign w_accept = !branchTaken && (r_state == WAIT) && imem_valid;
    assign w_push   = w_accept && !w_full;
    assign w_pop    = !branchTaken && !stall && !w_empty;

    fetch_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_clear   (branchTaken),
        .i_data    ({imem_data, imem_addr}),
        .o_data_c  (w_head),
        .o_count   (w_count),
        .o_empty_c (w_empty),
        .o_full_c  (w_full)
    );

    // Request FSM; a branch redirects fetchPC and turns an open request into a flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
        end else begin
            imem_req <= 1'b0;
            if (branchTaken) begin
                r_fetch_pc <= branchTarget;
                case (r_state)
                    WAIT:    r_state <= imem_valid ? IDLE : FLUSH_WAIT;
                    default: r_state <= imem_valid ? IDLE : r_state;
                endcase
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_count < CNT_W'(DEPTH)) begin
                            imem_req   <= 1'b1;
                            imem_addr  <= r_fetch_pc;
                            r_fetch_pc <= r_fetch_pc + WIDTH'(1);
                            r_state    <= WAIT;
                        end
                    end
                    WAIT, FLUSH_WAIT: begin
                        if (imem_valid) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // IF/ID register: holds under stall, bubbles when starved or flushed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instruction <= INSTRUCTIONWIDTH'(NOP_INSTR);
            PC          <= '0;
            instrValid  <= 1'b0;
        end else if (branchTaken || (!stall && w_empty)) begin
            instruction <= INSTRUCTIONWIDTH'(NOP_INSTR);
            PC          <= '0;
            instrValid  <= 1'b0;
        end else if (!stall) begin
            instruction <= w_head[ENTRY_W-1 -: INSTRUCTIONWIDTH];
            PC          <= w_head[WIDTH-1:0];
            instrValid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a latency-programmable instruction memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [23:0] imem_addr;
    logic        imem_valid;
    logic [23:0] imem_data;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [23:0] branchTarget = '0;
    logic [23:0] instruction;
    logic [23:0] PC;
    logic        instrValid;

    logic        m_valid = 1'b0;
    logic [23:0] m_data = '0;
    logic        s_valid = 1'b0;
    logic [23:0] s_data = '0;
    assign imem_valid = m_valid | s_valid;
    assign imem_data  = s_valid ? s_data : m_data;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    fetch_unit #(.WIDTH(24), .INSTRUCTIONWIDTH(24), .DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .instruction  (instruction),
        .PC           (PC),
        .instrValid   (instrValid)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] exp_word(input logic [23:0] a);
        return 24'h100000 + a;
    endfunction

    // Memory model: answers each request mem_lat cycles after the request cycle.
    int          mem_lat = 1;
    bit          mem_en  = 1'b1;
    bit          pend    = 1'b0;
    int          cnt     = 0;
    logic [23:0] paddr   = '0;
    always @(posedge clock) begin
        #1;
        m_valid = 1'b0;
        if (!mem_en) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cnt = cnt - 1;
                if (cnt <= 0) begin
                    m_valid = 1'b1;
                    m_data  = exp_word(paddr);
                    pend    = 1'b0;
                end
            end
            if (imem_req) begin
                pend  = 1'b1;
                cnt   = mem_lat;
                paddr = imem_addr;
            end
        end
    end

    // Output monitor: every freshly loaded valid IF/ID word must match the queue head.
    bit upd;
    always @(posedge clock) begin
        upd = reset && !stall && !branchTaken;
        #1;
        if (upd && instrValid) begin
            n_out = n_out + 1;
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL out_unexpected: got pc=%h instr=%h, required no output", PC, instruction);
            end else begin
                mon_e = exp_q.pop_front();
                if (PC !== mon_e.pc || instruction !== mon_e.instr) begin
                    bad = bad + 1;
                    $display("FAIL out_word: got pc=%h instr=%h, required pc=%h instr=%h",
                             PC, instruction, mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset && dut.w_accept) begin
            total = total + 1;
            if (dut.w_full) begin
                bad = bad + 1;
                $display("FAIL fifo_overflow: got push while full, required no push when full");
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total = total + 1;
        if (got !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic push_exp(input logic [23:0] pc0, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = pc0 + 24'(i);
            e.instr = exp_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_req(input string name, input logic [23:0] a);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!imem_req && k < 30);
        chk({name, "_seen"}, 32'(imem_req), 32'd1);
        chk(name, 32'(imem_addr), 32'(a));
    endtask

    task automatic wait_out(input string name, input int n);
        int k = 0;
        while (n_out < n && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk(name, 32'(n_out >= n), 32'd1);
    endtask

    task automatic do_branch(input logic [23:0] tgt);
        branchTaken  = 1'b1;
        branchTarget = tgt;
        exp_q.delete();
        push_exp(tgt, 8);
        @(negedge clock);
        branchTaken = 1'b0;
        chk("br_valid", 32'(instrValid), 32'd0);
        chk("br_pc", 32'(PC), 32'd0);
        chk("br_instr", 32'(instruction), 32'd0);
    endtask

    task automatic wait_cond(input string name, input bit want_valid);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(want_valid ? imem_valid : imem_req) && k < 30);
        chk(name, 32'(want_valid ? imem_valid : imem_req), 32'd1);
    endtask

    initial begin
        int base;
        int nreq;

        repeat (2) @(negedge clock);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_valid", 32'(instrValid), 32'd0);

        // Straight-line fetch from address 0
        push_exp(24'h0, 20);
        reset = 1'b1;
        wait_req("addr0", 24'h0);
        wait_req("addr1", 24'h1);
        wait_req("addr2", 24'h2);
        wait_req("addr3", 24'h3);

        // Stall with word 3 on IF/ID: FIFO fills with words 4..7, then requests stop
        wait_out("pre_stall", 4);
        stall = 1'b1;
        nreq  = 0;
        for (int i = 0; i < 16; i++) begin
            if (imem_req) nreq++;
            chk("stall_hold_instr", 32'(instruction), 32'h100003);
            chk("stall_hold_pc", 32'(PC), 32'd3);
            @(negedge clock);
        end
        chk("stall_req_count", 32'(nreq), 32'd4);
        chk("stall_req_idle", 32'(imem_req), 32'd0);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("drain_valid", 32'(instrValid), 32'd1);
        end

        // Branch while a slow response is outstanding
        mem_lat = 3;
        wait_cond("wait_for_req", 1'b0);
        mem_lat = 1;
        do_branch(24'h000040);
        base = n_out;
        wait_req("br_target_addr", 24'h000040);
        wait_out("br_target_out", base + 4);

        // Branch coinciding with the response strobe
        wait_cond("wait_for_resp", 1'b1);
        do_branch(24'h000080);
        @(negedge clock);
        chk("same_cyc_req", 32'(imem_req), 32'd1);
        chk("same_cyc_addr", 32'(imem_addr), 32'h80);
        base = n_out;
        wait_out("same_cyc_out", base + 3);

        // Address wrap-around
        do_branch(24'hFFFFFF);
        base = n_out;
        wait_req("wrap_addr_hi", 24'hFFFFFF);
        wait_req("wrap_addr_lo", 24'h000000);
        wait_out("wrap_out", base + 3);

        // Reset during WAIT, then a stray response right after release
        wait_cond("wait_for_req2", 1'b0);
        reset  = 1'b0;
        mem_en = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_instr", 32'(instruction), 32'd0);
        chk("mid_rst_pc", 32'(PC), 32'd0);
        chk("mid_rst_valid", 32'(instrValid), 32'd0);
        @(negedge clock);
        push_exp(24'h0, 6);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 24'hABCDEF;
        mem_en  = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", 32'(imem_addr), 32'd0);
        base = n_out;
        wait_out("restart_out", base + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
